// File: rtl/div_pkg.sv
// Shared types for the pipelined divider: op encoding, op decode helpers and per-stage control payload.
// Width-dependent payload (rem, quo, divisor, a_orig, tag, pc) travels as separate vectors so module parameters stay free.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef struct packed {
    logic    valid;
    div_op_e op;
    logic    sign_q;
    logic    sign_r;
    logic    dz;
    logic    ovf;
  } div_ctl_t;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_stage.sv
// One restoring-division register stage: BPS quotient bits per clock, one cycle of latency.
// Holds everything while en is low; kill clears the valid bit even when held.
module div_stage
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 7,
  parameter int PC_W  = 32,
  parameter int BPS   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             kill,
  input  div_ctl_t         src_ctl,
  input  logic [XLEN-1:0]  src_rem,
  input  logic [XLEN-1:0]  src_quo,
  input  logic [XLEN-1:0]  src_dsr,
  input  logic [XLEN-1:0]  src_a,
  input  logic [TAG_W-1:0] src_tag,
  input  logic [PC_W-1:0]  src_pc,
  output div_ctl_t         ctl,
  output logic [XLEN-1:0]  rem,
  output logic [XLEN-1:0]  quo,
  output logic [XLEN-1:0]  dsr,
  output logic [XLEN-1:0]  a_orig,
  output logic [TAG_W-1:0] tag,
  output logic [PC_W-1:0]  pc
);

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  // quo starts as the dividend magnitude: its MSB feeds the remainder, quotient bits shift in at the LSB.
  always_comb begin
    trial   = '0;
    rem_nxt = src_rem;
    quo_nxt = src_quo;
    for (int i = 0; i < BPS; i++) begin
      trial   = {rem_nxt, quo_nxt[XLEN-1]};
      quo_nxt = {quo_nxt[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, src_dsr}) begin
        trial      = trial - {1'b0, src_dsr};
        quo_nxt[0] = 1'b1;
      end
      rem_nxt = trial[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl    <= '0;
      rem    <= '0;
      quo    <= '0;
      dsr    <= '0;
      a_orig <= '0;
      tag    <= '0;
      pc     <= '0;
    end else begin
      if (en) begin
        ctl    <= src_ctl;
        rem    <= rem_nxt;
        quo    <= quo_nxt;
        dsr    <= src_dsr;
        a_orig <= src_a;
        tag    <= src_tag;
        pc     <= src_pc;
      end
      if (kill) ctl.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/div_pipe_rv.sv
// Pipelined RISC-V DIV/DIVU/REM/REMU, one op per cycle, accept->out_valid = XLEN/BPS+2 cycles; out stall freezes all stages.
// DIV_FLUSH_EN: flush clears every in-flight op at the next edge, overriding stall; otherwise flush is ignored.
module div_pipe_rv
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 7,
  parameter int PC_W  = 32,
  parameter int BPS   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_dz
);

  localparam int N = XLEN / BPS;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic stall;
  logic en;
  logic kill;

  assign stall = out_valid & ~out_ready;
  assign en    = ~stall;

`ifdef DIV_FLUSH_EN
  assign kill     = flush;
  assign in_ready = ~stall | flush;
`else
  logic flush_unused;
  assign flush_unused = flush;
  assign kill         = 1'b0;
  assign in_ready     = ~stall;
`endif

  div_op_e         op;
  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  div_ctl_t        prep;

  always_comb begin
    op          = div_op_e'(in_op);
    sgn         = op_is_signed(op);
    a_neg       = sgn & in_a[XLEN-1];
    b_neg       = sgn & in_b[XLEN-1];
    a_mag       = a_neg ? -in_a : in_a;
    b_mag       = b_neg ? -in_b : in_b;
    prep        = '0;
    prep.valid  = in_valid;
    prep.op     = op;
    prep.sign_q = a_neg ^ b_neg;
    prep.sign_r = a_neg;
    prep.dz     = (in_b == '0);
    prep.ovf    = sgn & (in_a == MIN) & (in_b == '1);
  end

  div_ctl_t         s0_ctl;
  logic [XLEN-1:0]  s0_quo;
  logic [XLEN-1:0]  s0_dsr;
  logic [XLEN-1:0]  s0_a;
  logic [TAG_W-1:0] s0_tag;
  logic [PC_W-1:0]  s0_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_ctl <= '0;
      s0_quo <= '0;
      s0_dsr <= '0;
      s0_a   <= '0;
      s0_tag <= '0;
      s0_pc  <= '0;
    end else begin
      if (en) begin
        s0_ctl <= prep;
        s0_quo <= a_mag;
        s0_dsr <= b_mag;
        s0_a   <= in_a;
        s0_tag <= in_tag;
        s0_pc  <= in_pc;
      end
      if (kill) s0_ctl.valid <= 1'b0;
    end
  end

  // Index 0 is the prep stage; index k is the output of iteration stage k.
  div_ctl_t         ctl_s [N+1];
  logic [XLEN-1:0]  rem_s [N+1];
  logic [XLEN-1:0]  quo_s [N+1];
  logic [XLEN-1:0]  dsr_s [N+1];
  logic [XLEN-1:0]  a_s   [N+1];
  logic [TAG_W-1:0] tag_s [N+1];
  logic [PC_W-1:0]  pc_s  [N+1];

  assign ctl_s[0] = s0_ctl;
  assign rem_s[0] = '0;
  assign quo_s[0] = s0_quo;
  assign dsr_s[0] = s0_dsr;
  assign a_s[0]   = s0_a;
  assign tag_s[0] = s0_tag;
  assign pc_s[0]  = s0_pc;

  for (genvar k = 1; k <= N; k++) begin : g_iter
    div_stage #(
      .XLEN  (XLEN),
      .TAG_W (TAG_W),
      .PC_W  (PC_W),
      .BPS   (BPS)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .kill    (kill),
      .src_ctl (ctl_s[k-1]),
      .src_rem (rem_s[k-1]),
      .src_quo (quo_s[k-1]),
      .src_dsr (dsr_s[k-1]),
      .src_a   (a_s[k-1]),
      .src_tag (tag_s[k-1]),
      .src_pc  (pc_s[k-1]),
      .ctl     (ctl_s[k]),
      .rem     (rem_s[k]),
      .quo     (quo_s[k]),
      .dsr     (dsr_s[k]),
      .a_orig  (a_s[k]),
      .tag     (tag_s[k]),
      .pc      (pc_s[k])
    );
  end

  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] res_fix;

  // Divide-by-zero and overflow overrides win over the sign fix-up.
  always_comb begin
    q_fix = ctl_s[N].sign_q ? -quo_s[N] : quo_s[N];
    r_fix = ctl_s[N].sign_r ? -rem_s[N] : rem_s[N];
    if (ctl_s[N].dz) begin
      q_fix = '1;
      r_fix = a_s[N];
    end
    if (ctl_s[N].ovf) begin
      q_fix = MIN;
      r_fix = '0;
    end
    res_fix = op_is_rem(ctl_s[N].op) ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_pc     <= '0;
      out_dz     <= 1'b0;
    end else begin
      if (en) begin
        out_valid  <= ctl_s[N].valid;
        out_result <= res_fix;
        out_tag    <= tag_s[N];
        out_pc     <= pc_s[N];
        out_dz     <= ctl_s[N].dz;
      end
      if (kill) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_pipe_rv.sv
// Randomized and directed bench for div_pipe_rv against an arithmetic reference model with an in-order scoreboard.
module tb_div_pipe_rv;

  localparam int XLEN  = 32;
  localparam int TAG_W = 7;
  localparam int PC_W  = 32;
  localparam int BPS   = 1;
  localparam int LAT   = XLEN / BPS + 2;
`ifdef DIV_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic [PC_W-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic [PC_W-1:0]  out_pc;
  logic             out_dz;

  always #5 clk = ~clk;

  div_pipe_rv #(.XLEN(XLEN), .TAG_W(TAG_W), .PC_W(PC_W), .BPS(BPS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_pc     (out_pc),
    .out_dz     (out_dz)
  );

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  pc;
    logic             dz;
  } exp_t;

  exp_t exp_q[$];
  exp_t head;
  int   n_vec = 0;
  int   n_mis = 0;
  int   n_out = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RISC-V division semantics straight from the ISA rules.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] tag, input logic [PC_W-1:0] pc);
    exp_t e;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (op[0] == 1'b0) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    e.res = op[1] ? r : q;
    e.tag = tag;
    e.pc  = pc;
    e.dz  = (b == 32'd0);
    return e;
  endfunction

  logic             prev_stall = 1'b0;
  logic [XLEN-1:0]  prev_res;
  logic [TAG_W-1:0] prev_tag;
  logic [PC_W-1:0]  prev_pc;
  logic             prev_dz;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_result", out_result, prev_res);
        check_val("hold_tag", out_tag, prev_tag);
        check_val("hold_pc", out_pc, prev_pc);
        check_val("hold_dz", out_dz, prev_dz);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_val("spurious_out", exp_q.size(), 1);
        end else begin
          head = exp_q.pop_front();
          check_val("result", out_result, head.res);
          check_val("tag", out_tag, head.tag);
          check_val("pc", out_pc, head.pc);
          check_val("dz", out_dz, head.dz);
        end
      end
      prev_stall = out_valid && !out_ready && !(FLUSH_ON && flush);
      prev_res   = out_result;
      prev_tag   = out_tag;
      prev_pc    = out_pc;
      prev_dz    = out_dz;
      if (FLUSH_ON && flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b, in_tag, in_pc));
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [PC_W-1:0] pc);
    logic acc;
    int   waited;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    in_pc    = pc;
    acc      = 1'b0;
    waited   = 0;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!acc) check_val("issue_timeout", acc, 1);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    check_val(tag, exp_q.size(), 0);
  endtask

  task automatic wait_out_valid(input string tag);
    for (int c = 0; c < 200 && !out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    check_val(tag, out_valid, 1);
  endtask

  function automatic logic [31:0] pick_a();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] pick_b();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(1, 16));
      default: return $urandom();
    endcase
  endfunction

  int cnt;
  int base;

  initial begin
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_result", out_result, 0);
    check_val("rst_out_tag", out_tag, 0);
    check_val("rst_out_pc", out_pc, 0);
    check_val("rst_out_dz", out_dz, 0);
    check_val("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    issue(2'b01, 32'd100, 32'd7, 7'd5, 32'h40);
    cnt = 1;
    while (!out_valid && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_val("latency", cnt, LAT);
    issue(2'b11, 32'd100, 32'd7, 7'd6, 32'h44);
    drain("drain_basic");

    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 7'd10, 32'h100);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 7'd11, 32'h104);
    issue(2'b00, 32'd7, 32'hFFFF_FFFE, 7'd12, 32'h108);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 7'd13, 32'h10C);
    issue(2'b01, 32'h1234, 32'd0, 7'd14, 32'h110);
    issue(2'b10, 32'h1234, 32'd0, 7'd15, 32'h114);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 7'd16, 32'h118);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 7'd17, 32'h11C);
    drain("drain_special");

    fork
      for (int i = 0; i < 34; i++)
        issue(2'(i % 4), $urandom(), 32'($urandom_range(1, 1000)), 7'(i), 32'h1000 + 32'(4 * i));
      begin
        wait_out_valid("stream_first_out");
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_stream");

    fork
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        issue(2'($urandom_range(0, 3)), pick_a(), pick_b(), 7'($urandom), $urandom());
      end
      begin
        for (int c = 0; c < 500; c++) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain("drain_random");

`ifdef DIV_FLUSH_EN
    for (int i = 0; i < 10; i++) issue(2'b01, 32'd500 + 32'(i), 32'd3, 7'(40 + i), 32'h2000 + 32'(4 * i));
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_a     = 32'd99;
    in_b     = 32'd9;
    in_tag   = 7'd60;
    in_pc    = 32'h2100;
    flush    = 1'b1;
    @(negedge clk);
    check_val("flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_val("flush_out_valid", out_valid, 0);
    base = n_out;
    issue(2'b01, 32'd1000, 32'd10, 7'd61, 32'h2200);
    drain("drain_flush");
    check_val("flush_survivors", n_out - base, 1);
`endif

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(2'b00, $urandom(), 32'd5, 7'(70 + i), 32'h3000 + 32'(4 * i));
    wait_out_valid("arst_pre_valid");
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_out_valid", out_valid, 0);
    check_val("arst_out_result", out_result, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    base = n_out;
    issue(2'b11, 32'd77, 32'd10, 7'd80, 32'h3100);
    drain("drain_arst");
    check_val("arst_survivors", n_out - base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
